// File: rtl/capture_pkg.sv
// Shared encodings for the multi-channel capture block: capture modes and
// the single-shot arm state.
package capture_pkg;

  typedef enum logic [1:0] {
    MODE_PERIODIC = 2'd0,
    MODE_SINGLE   = 2'd1,
    MODE_CHANGE   = 2'd2,
    MODE_HOLD     = 2'd3
  } mode_e;

  typedef enum logic {
    ARM_IDLE = 1'b0,
    ARM_SET  = 1'b1
  } arm_e;

endpackage

// File: rtl/capture_tick.sv
// Reset stretcher and capture interval generator: w_rst stays high while i_rst
// is high and for pRST_LEN cycles afterwards; tick fires every i_period+1 cycles.
module capture_tick #(
  parameter int pCNT_W   = 16,
  parameter int pRST_LEN = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [pCNT_W-1:0] i_period,
  output logic              w_rst,
  output logic              tick
);

  logic [pRST_LEN-1:0] rst_sr_reg;
  logic [pCNT_W-1:0]   cnt_reg;

  // Loaded with ones while i_rst is high, then drained one bit per cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rst_sr_reg <= '1;
    end else begin
      rst_sr_reg <= rst_sr_reg >> 1;
    end
  end

  assign w_rst = i_rst | (|rst_sr_reg);

  // >= rather than == so that lowering i_period below the count ticks at once.
  assign tick = !w_rst && (cnt_reg >= i_period);

  always_ff @(posedge i_clk) begin
    if (w_rst) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/capture_multi.sv
// Multi-channel sampler: captures all channels on qualified ticks according to
// the selected mode and reports per-channel change flags and a capture count.
module capture_multi
  import capture_pkg::*;
#(
  parameter int pCHAN    = 3,
  parameter int pWIDTH   = 5,
  parameter int pCNT_W   = 16,
  parameter int pRST_LEN = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [pCHAN*pWIDTH-1:0] i_data,
  input  logic [pCNT_W-1:0]       i_period,
  input  logic [1:0]              i_mode,
  input  logic                    i_arm,
  output logic [pCHAN*pWIDTH-1:0] o_data,
  output logic                    o_valid,
  output logic [pCHAN-1:0]        o_changed,
  output logic [7:0]              o_seq,
  output logic                    o_armed
);

  logic       w_rst;
  logic       tick;
  mode_e      mode;
  logic [pCHAN-1:0] diff;
  logic       qual;
  logic       capture;
  arm_e       arm_state_reg;
  arm_e       arm_state_next;
  logic [7:0] seq_reg;
  logic       valid_reg;
  logic       first_reg;

  capture_tick #(
    .pCNT_W   (pCNT_W),
    .pRST_LEN (pRST_LEN)
  ) u_tick (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_period (i_period),
    .w_rst    (w_rst),
    .tick     (tick)
  );

  assign mode = mode_e'(i_mode);

  // Per-channel held value and change flag.
  generate
    for (genvar gi = 0; gi < pCHAN; gi++) begin : g_chan
      logic [pWIDTH-1:0] chan_reg;
      logic              changed_reg;

      assign diff[gi] = i_data[gi*pWIDTH +: pWIDTH] != chan_reg;

      always_ff @(posedge i_clk) begin
        if (w_rst) begin
          chan_reg    <= '0;
          changed_reg <= 1'b0;
        end else if (capture) begin
          chan_reg    <= i_data[gi*pWIDTH +: pWIDTH];
          changed_reg <= diff[gi];
        end
      end

      assign o_data[gi*pWIDTH +: pWIDTH] = chan_reg;
      assign o_changed[gi]               = changed_reg;
    end
  endgenerate

  always_comb begin
    qual = 1'b0;
    case (mode)
      MODE_PERIODIC: qual = 1'b1;
      MODE_SINGLE:   qual = (arm_state_reg == ARM_SET) || i_arm;
      MODE_CHANGE:   qual = (|diff) || first_reg;
      MODE_HOLD:     qual = 1'b0;
      default:       qual = 1'b0;
    endcase
  end

  assign capture = tick && qual;

  // Arm state: cleared by leaving single-shot mode or by the shot itself.
  always_comb begin
    arm_state_next = arm_state_reg;
    if (mode != MODE_SINGLE || capture) begin
      arm_state_next = ARM_IDLE;
    end else if (i_arm) begin
      arm_state_next = ARM_SET;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_rst) begin
      arm_state_reg <= ARM_IDLE;
    end else begin
      arm_state_reg <= arm_state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_rst) begin
      seq_reg   <= 8'd0;
      valid_reg <= 1'b0;
      first_reg <= 1'b1;
    end else begin
      valid_reg <= capture;
      if (capture) begin
        seq_reg   <= seq_reg + 8'd1;
        first_reg <= 1'b0;
      end
    end
  end

  assign o_seq   = seq_reg;
  assign o_valid = valid_reg;
  assign o_armed = (arm_state_reg == ARM_SET);

endmodule

// File: doc/capture_multi.md
CAPTURE_MULTI -- requirements
Module: capture_multi

Interface
REQ-001 pCHAN, 3, number of sampled channels (1..16).
REQ-002 pWIDTH, 5, bits per channel (1..32).
REQ-003 pCNT_W, 16, width of period counter and i_period.
REQ-004 pRST_LEN, 8, internal reset stretch length in cycles (>=1).
REQ-005 i_clk  in  1  clock; all logic on rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_data  in  pCHAN*pWIDTH  channel inputs; channel k at bits [k*pWIDTH +: pWIDTH].
REQ-008 i_period  in  pCNT_W  capture interval minus one; sampled every cycle.
REQ-009 i_mode  in  2  0=periodic, 1=single-shot, 2=on-change, 3=hold.
REQ-010 i_arm  in  1  single-shot arm request, level sampled per cycle.
REQ-011 o_data  out  pCHAN*pWIDTH  held capture, same channel packing as i_data.
REQ-012 o_valid  out  1  one-cycle pulse, high the cycle after a capture edge.
REQ-013 o_changed  out  pCHAN  per-channel flag: channel differed from previous held value at last capture.
REQ-014 o_seq  out  8  capture count, increments per capture, wraps 255->0.
REQ-015 o_armed  out  1  single-shot armed state.

Function
REQ-016 Internal reset w_rst SHALL be high while i_rst is high and for pRST_LEN cycles after i_rst falls (shift-register stretch, all ones on i_rst).
REQ-017 Counter SHALL clear under w_rst; otherwise tick = (cnt >= i_period); on tick cnt <- 0, else cnt <- cnt+1.
REQ-018 Interval between ticks SHALL be i_period+1 cycles; i_period=0 ticks every cycle; lowering i_period below cnt ticks on the next edge.
REQ-019 Capture edge = tick AND mode qualifier: mode 0 always; mode 1 armed (or i_arm high that cycle); mode 2 i_data != o_data or first capture since reset; mode 3 never.
REQ-020 On a capture edge o_data <= i_data, o_changed <= per-channel (i_data != o_data), o_seq <= o_seq+1, o_valid <= 1; otherwise o_valid <= 0 and other outputs hold.
REQ-021 Latency: data present on i_data at the capture edge SHALL appear on o_data with o_valid high in the following cycle.
REQ-022 Single-shot: i_arm high sets armed; capture edge in mode 1 clears armed; i_arm while armed has no further effect; i_arm coincident with tick SHALL capture on that tick and leave armed clear.
REQ-023 Leaving mode 1 SHALL clear armed; i_arm is ignored in modes 0, 2, 3.
REQ-024 i_mode changes SHALL take effect at the edge they are sampled; counter is never reset by mode change.
REQ-025 Mode 3 SHALL keep counter running and outputs frozen, o_valid low.

Reset
REQ-026 While w_rst: o_data=0, o_changed=0, o_seq=0, o_valid=0, armed=0, cnt=0, first-capture flag set.
REQ-027 i_rst asserted mid-interval SHALL abort pending tick and armed state; first tick after release occurs i_period+1 cycles after w_rst falls.

Structure
REQ-028 Mode encodings (MODE_PERIODIC, MODE_SINGLE, MODE_CHANGE, MODE_HOLD) SHALL live in shared package capture_pkg.
REQ-029 Reset stretch and tick generator SHALL be one sub-module capture_tick (params pCNT_W, pRST_LEN; outputs w_rst, tick).
REQ-030 Channel compare and capture registers SHALL be generate-looped over pCHAN.

Verification
REQ-031 Mode 0, i_period=3, i_data constant 0x1234 (pCHAN=3,pWIDTH=5) -> o_valid every 4 cycles, o_seq 1,2,3..., o_changed=0 after first.
REQ-032 i_rst 1 cycle then release -> outputs zero for 1+8 cycles; first o_valid at cycle 9+i_period+1 after release.
REQ-033 Mode 1, i_period=9, i_arm pulse at cnt=2 -> exactly one o_valid at next tick; second i_arm while armed -> no extra capture; i_arm on tick cycle -> capture same tick.
REQ-034 Mode 2, i_period=0, channel 1 toggles once -> exactly two o_valid (first capture, toggle), o_changed=3'b010 on second.
REQ-035 o_seq after 256 captures -> 0; i_period lowered from 100 to 5 at cnt=50 -> tick next edge, then every 6 cycles.
REQ-036 Mode 3 for 50 cycles with changing i_data -> o_data and o_seq unchanged, o_valid never high.
